// File: rtl/div_share_arb.sv
// Round-robin sharing of one fixed-latency pipelined divider between the HSV
// saturation (req0) and hue (req1) stages, with tag-based result routing.
module div_share_arb #(
    parameter int DIVIDE_LATENCY = 16,
    parameter int DW             = 9,
    parameter int QW             = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [DW-1:0] i_req0_dividend,
    input  logic [DW-1:0] i_req0_divisor,
    input  logic          i_req1_valid,
    input  logic [DW-1:0] i_req1_dividend,
    input  logic [DW-1:0] i_req1_divisor,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    output logic          o_div_valid,
    output logic [DW-1:0] o_div_dividend,
    output logic [DW-1:0] o_div_divisor,
    input  logic          i_div_valid,
    input  logic [QW-1:0] i_div_quotient,
    output logic          o_res0_valid,
    output logic [QW-1:0] o_res0_quotient,
    output logic          o_res0_divzero,
    output logic          o_res1_valid,
    output logic [QW-1:0] o_res1_quotient,
    output logic          o_res1_divzero,
    output logic          o_busy,
    output logic          o_sync_err
);

    localparam int LAST = DIVIDE_LATENCY;
    localparam int TW   = $clog2(DIVIDE_LATENCY + 2);

    logic          ptr;
    logic          grant0;
    logic          grant1;
    logic          xfer;
    logic [DW-1:0] sel_dividend;
    logic [DW-1:0] sel_divisor;
    logic [LAST:0] tag_v;
    logic [LAST:0] tag_id;
    logic [LAST:0] tag_dz;
    logic [TW-1:0] flush_cnt;
    logic          sync_mask;
    logic [QW-1:0] res_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!i_rst) begin
            if (i_req0_valid && (!i_req1_valid || !ptr))
                grant0 = 1'b1;
            else if (i_req1_valid)
                grant1 = 1'b1;
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign xfer         = grant0 | grant1;
    assign sel_dividend = grant1 ? i_req1_dividend : i_req0_dividend;
    assign sel_divisor  = grant1 ? i_req1_divisor  : i_req0_divisor;

    // Quotients still draining from before reset must not look like sync errors.
    assign sync_mask = (flush_cnt != '0) && (tag_v == '0);
    assign res_q     = tag_dz[LAST] ? '0 : i_div_quotient;
    assign o_busy    = o_div_valid | (|tag_v);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr             <= 1'b0;
            o_div_valid     <= 1'b0;
            o_div_dividend  <= '0;
            o_div_divisor   <= '0;
            tag_v           <= '0;
            tag_id          <= '0;
            tag_dz          <= '0;
            flush_cnt       <= TW'(DIVIDE_LATENCY + 1);
            o_res0_valid    <= 1'b0;
            o_res0_quotient <= '0;
            o_res0_divzero  <= 1'b0;
            o_res1_valid    <= 1'b0;
            o_res1_quotient <= '0;
            o_res1_divzero  <= 1'b0;
            o_sync_err      <= 1'b0;
        end else begin
            if (xfer) begin
                ptr            <= grant0;
                o_div_dividend <= sel_dividend;
                o_div_divisor  <= sel_divisor;
            end
            o_div_valid <= xfer;
            tag_v  <= {tag_v[LAST-1:0],  xfer};
            tag_id <= {tag_id[LAST-1:0], grant1};
            tag_dz <= {tag_dz[LAST-1:0], xfer && (sel_divisor == '0)};
            if (flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
            o_res0_valid <= tag_v[LAST] && !tag_id[LAST];
            o_res1_valid <= tag_v[LAST] &&  tag_id[LAST];
            if (tag_v[LAST] && !tag_id[LAST]) begin
                o_res0_quotient <= res_q;
                o_res0_divzero  <= tag_dz[LAST];
            end
            if (tag_v[LAST] && tag_id[LAST]) begin
                o_res1_quotient <= res_q;
                o_res1_divzero  <= tag_dz[LAST];
            end
            if ((tag_v[LAST] != i_div_valid) && !sync_mask)
                o_sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with a 16-cycle pipelined divider model
// computing floor((dividend<<8)/divisor).
module tb_div_share_arb;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req0_valid = 1'b0;
    logic [8:0]  i_req0_dividend = '0;
    logic [8:0]  i_req0_divisor = '0;
    logic        i_req1_valid = 1'b0;
    logic [8:0]  i_req1_dividend = '0;
    logic [8:0]  i_req1_divisor = '0;
    logic        o_req0_ready, o_req1_ready;
    logic        o_div_valid;
    logic [8:0]  o_div_dividend, o_div_divisor;
    logic        i_div_valid;
    logic [15:0] i_div_quotient;
    logic        o_res0_valid, o_res0_divzero;
    logic [15:0] o_res0_quotient;
    logic        o_res1_valid, o_res1_divzero;
    logic [15:0] o_res1_quotient;
    logic        o_busy, o_sync_err;

    div_share_arb #(.DIVIDE_LATENCY(16), .DW(9), .QW(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .i_req0_dividend(i_req0_dividend),
        .i_req0_divisor(i_req0_divisor),
        .i_req1_valid(i_req1_valid), .i_req1_dividend(i_req1_dividend),
        .i_req1_divisor(i_req1_divisor),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .o_div_valid(o_div_valid), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor),
        .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient),
        .o_res0_valid(o_res0_valid), .o_res0_quotient(o_res0_quotient),
        .o_res0_divzero(o_res0_divzero),
        .o_res1_valid(o_res1_valid), .o_res1_quotient(o_res1_quotient),
        .o_res1_divzero(o_res1_divzero),
        .o_busy(o_busy), .o_sync_err(o_sync_err)
    );

    always #5 i_clk = ~i_clk;

    // Divider model: 16 register stages; one chosen issue can have its valid dropped.
    logic [15:0] mv = '0;
    logic [15:0] mq [16];
    int          issue_cnt = 0;
    int          drop_idx = -1;

    function automatic logic [15:0] model_q(input logic [8:0] a, input logic [8:0] b);
        int n;
        if (b == 9'd0) return 16'hFFFF;
        n = int'(a) << 8;
        return 16'(n / int'(b));
    endfunction

    always @(posedge i_clk) begin
        for (int i = 15; i > 0; i--) mq[i] <= mq[i-1];
        mq[0] <= model_q(o_div_dividend, o_div_divisor);
        mv    <= {mv[14:0], o_div_valid && (issue_cnt != drop_idx)};
        if (o_div_valid) issue_cnt <= issue_cnt + 1;
    end

    assign i_div_valid    = mv[15];
    assign i_div_quotient = mq[15];

    typedef struct packed {
        int          cyc;
        logic [15:0] q;
        logic        dz;
    } res_t;

    res_t r0[$];
    res_t r1[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic step();
        res_t e;
        @(negedge i_clk);
        #1;
        cyc++;
        if (o_res0_valid) begin
            e.cyc = cyc; e.q = o_res0_quotient; e.dz = o_res0_divzero;
            r0.push_back(e);
        end
        if (o_res1_valid) begin
            e.cyc = cyc; e.q = o_res1_quotient; e.dz = o_res1_divzero;
            r1.push_back(e);
        end
    endtask

    task automatic idle();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        r0.delete();
        r1.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_req0_valid = 1'b1; i_req0_dividend = 9'd5; i_req0_divisor = 9'd2;
        i_req1_valid = 1'b1; i_req1_dividend = 9'd7; i_req1_divisor = 9'd3;
        repeat (3) step();
        n_cmp++; if (o_req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0: got %b want 0", o_req0_ready); end
        n_cmp++; if (o_req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1: got %b want 0", o_req1_ready); end
        n_cmp++; if (o_div_valid !== 1'b0) begin n_err++; $display("FAIL rst_div_valid: got %b want 0", o_div_valid); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_sync_err !== 1'b0) begin n_err++; $display("FAIL rst_sync_err: got %b want 0", o_sync_err); end
        n_cmp++; if ({o_res0_valid, o_res1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_res_valid: got %b want 00", {o_res0_valid, o_res1_valid}); end
        n_cmp++; if (o_res0_quotient !== 16'h0) begin n_err++; $display("FAIL rst_res0_q: got %h want 0", o_res0_quotient); end
        idle();
        i_rst = 1'b0;
        repeat (2) step();
        r0.delete();
        r1.delete();
    endtask

    task automatic test_single();
        int c0;
        c0 = cyc;
        i_req0_valid = 1'b1; i_req0_dividend = 9'd5; i_req0_divisor = 9'd2;
        #1;
        n_cmp++; if (o_req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", o_req0_ready); end
        n_cmp++; if (o_req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1: got %b want 0", o_req1_ready); end
        step();
        idle();
        n_cmp++; if (o_div_valid !== 1'b1) begin n_err++; $display("FAIL single_div_valid: got %b want 1", o_div_valid); end
        n_cmp++; if ({o_div_dividend, o_div_divisor} !== {9'd5, 9'd2}) begin n_err++; $display("FAIL single_div_ops: got %0d/%0d want 5/2", o_div_dividend, o_div_divisor); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", o_busy); end
        repeat (20) step();
        n_cmp++; if (r0.size() != 1) begin n_err++; $display("FAIL single_res0_count: got %0d want 1", r0.size()); end
        if (r0.size() >= 1) begin
            n_cmp++; if (r0[0].cyc != c0 + 18) begin n_err++; $display("FAIL single_latency: got %0d want %0d", r0[0].cyc - c0, 18); end
            n_cmp++; if (r0[0].q !== 16'h0280) begin n_err++; $display("FAIL single_q: got %h want 0280", r0[0].q); end
            n_cmp++; if (r0[0].dz !== 1'b0) begin n_err++; $display("FAIL single_dz: got %b want 0", r0[0].dz); end
        end
        n_cmp++; if (r1.size() != 0) begin n_err++; $display("FAIL single_res1_count: got %0d want 0", r1.size()); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_round_robin();
        logic [8:0]  a0 [2] = '{9'd1, 9'd3};
        logic [8:0]  b0 [2] = '{9'd3, 9'd2};
        logic [8:0]  a1 [2] = '{9'd10, 9'd3};
        logic [8:0]  b1 [2] = '{9'd3, 9'd2};
        logic [15:0] e0 [2] = '{16'h0055, 16'h0180};
        logic [15:0] e1 [2] = '{16'h0355, 16'h0180};
        int i0, i1, c0;
        logic exp0;
        do_reset();
        i0 = 0; i1 = 0; c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            i_req0_valid = (i0 < 2);
            if (i0 < 2) begin i_req0_dividend = a0[i0]; i_req0_divisor = b0[i0]; end
            i_req1_valid = (i1 < 2);
            if (i1 < 2) begin i_req1_dividend = a1[i1]; i_req1_divisor = b1[i1]; end
            #1;
            exp0 = ((k % 2) == 0);
            n_cmp++; if ({o_req0_ready, o_req1_ready} !== {exp0, ~exp0}) begin n_err++; $display("FAIL rr_grant%0d: got %b%b want %b%b", k, o_req0_ready, o_req1_ready, exp0, ~exp0); end
            if (o_req0_ready) i0++;
            if (o_req1_ready) i1++;
            step();
        end
        idle();
        repeat (22) step();
        n_cmp++; if (r0.size() != 2 || r1.size() != 2) begin n_err++; $display("FAIL rr_counts: got %0d/%0d want 2/2", r0.size(), r1.size()); end
        for (int k = 0; k < 2; k++) begin
            if (r0.size() > k) begin
                n_cmp++; if (r0[k].q !== e0[k] || r0[k].cyc != c0 + 18 + 2*k) begin n_err++; $display("FAIL rr_res0_%0d: got %h@%0d want %h@%0d", k, r0[k].q, r0[k].cyc - c0, e0[k], 18 + 2*k); end
            end
            if (r1.size() > k) begin
                n_cmp++; if (r1[k].q !== e1[k] || r1[k].cyc != c0 + 19 + 2*k) begin n_err++; $display("FAIL rr_res1_%0d: got %h@%0d want %h@%0d", k, r1[k].q, r1[k].cyc - c0, e1[k], 19 + 2*k); end
            end
        end
    endtask

    task automatic test_divzero();
        r0.delete(); r1.delete();
        i_req1_valid = 1'b1; i_req1_dividend = 9'd25; i_req1_divisor = 9'd0;
        #1;
        n_cmp++; if (o_req1_ready !== 1'b1) begin n_err++; $display("FAIL dz_ready1: got %b want 1", o_req1_ready); end
        step();
        n_cmp++; if ({o_div_valid, o_div_dividend, o_div_divisor} !== {1'b1, 9'd25, 9'd0}) begin n_err++; $display("FAIL dz_issue0: got %b %0d/%0d want 1 25/0", o_div_valid, o_div_dividend, o_div_divisor); end
        i_req1_dividend = 9'd42;
        step();
        idle();
        n_cmp++; if ({o_div_valid, o_div_dividend, o_div_divisor} !== {1'b1, 9'd42, 9'd0}) begin n_err++; $display("FAIL dz_issue1: got %b %0d/%0d want 1 42/0", o_div_valid, o_div_dividend, o_div_divisor); end
        step();
        n_cmp++; if (o_div_valid !== 1'b0) begin n_err++; $display("FAIL dz_issue_end: got %b want 0", o_div_valid); end
        repeat (20) step();
        n_cmp++; if (r1.size() != 2 || r0.size() != 0) begin n_err++; $display("FAIL dz_counts: got %0d/%0d want 0/2", r0.size(), r1.size()); end
        for (int k = 0; k < 2; k++) begin
            if (r1.size() > k) begin
                n_cmp++; if ({r1[k].q, r1[k].dz} !== {16'h0, 1'b1}) begin n_err++; $display("FAIL dz_res1_%0d: got q=%h dz=%b want q=0 dz=1", k, r1[k].q, r1[k].dz); end
            end
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            i_req0_valid = 1'b1; i_req0_dividend = 9'(k + 9); i_req0_divisor = 9'd3;
            step();
        end
        idle();
        repeat (5) step();
        i_rst = 1'b1;
        i_req0_valid = 1'b1;
        #1;
        n_cmp++; if (o_req0_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready_in_rst: got %b want 0", o_req0_ready); end
        step();
        i_rst = 1'b0;
        idle();
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", o_busy); end
        repeat (25) step();
        n_cmp++; if (r0.size() != 0 || r1.size() != 0) begin n_err++; $display("FAIL flush_stale_results: got %0d/%0d want 0/0", r0.size(), r1.size()); end
        n_cmp++; if (o_sync_err !== 1'b0) begin n_err++; $display("FAIL flush_sync_err: got %b want 0", o_sync_err); end
    endtask

    task automatic test_sync_err();
        int c0;
        r0.delete(); r1.delete();
        drop_idx = issue_cnt;
        c0 = cyc;
        i_req0_valid = 1'b1; i_req0_dividend = 9'd7; i_req0_divisor = 9'd2;
        step();
        idle();
        repeat (16) step();
        n_cmp++; if (o_sync_err !== 1'b0) begin n_err++; $display("FAIL sync_early: got %b want 0", o_sync_err); end
        step();
        n_cmp++; if (o_sync_err !== 1'b1) begin n_err++; $display("FAIL sync_set: got %b want 1", o_sync_err); end
        n_cmp++; if (r0.size() != 1) begin n_err++; $display("FAIL sync_routed_count: got %0d want 1", r0.size()); end
        if (r0.size() >= 1) begin
            n_cmp++; if (r0[0].q !== 16'h0380 || r0[0].cyc != c0 + 18) begin n_err++; $display("FAIL sync_routed: got %h@%0d want 0380@18", r0[0].q, r0[0].cyc - c0); end
        end
        drop_idx = -1;
        repeat (5) step();
        n_cmp++; if (o_sync_err !== 1'b1) begin n_err++; $display("FAIL sync_sticky: got %b want 1", o_sync_err); end
        do_reset();
        n_cmp++; if (o_sync_err !== 1'b0) begin n_err++; $display("FAIL sync_cleared: got %b want 0", o_sync_err); end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        for (int k = 0; k < 20; k++) begin
            i_req0_valid = 1'b1; i_req0_dividend = 9'(k + 1); i_req0_divisor = 9'd2;
            #1;
            n_cmp++; if (o_req0_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", k, o_req0_ready); end
            step();
        end
        idle();
        repeat (20) step();
        n_cmp++; if (r0.size() != 20) begin n_err++; $display("FAIL b2b_count: got %0d want 20", r0.size()); end
        for (int k = 0; k < 20; k++) begin
            if (r0.size() > k) begin
                n_cmp++; if (r0[k].q !== 16'((k + 1) * 128) || r0[k].cyc != c0 + 18 + k) begin n_err++; $display("FAIL b2b_res_%0d: got %h@%0d want %h@%0d", k, r0[k].q, r0[k].cyc - c0, 16'((k + 1) * 128), 18 + k); end
            end
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy: got %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_divzero();
        test_reset_flush();
        test_sync_err();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin arbiter and result router sharing one fixed-latency pipelined divider between two requesters of the colour-detect HSV path: requester 0 is the saturation stage (delta/value), requester 1 is the hue stage (delta-based hue ratio). It accepts at most one division per cycle. It tracks each in-flight operation with a tag pipeline matched to the divider latency and returns each quotient to the requester that issued it. Zero divisors are flagged, with a forced-zero quotient.

## Interface

Parameters:
- DIVIDE_LATENCY, 16, cycles from divider sampling operands to its quotient valid
- DW, 9, operand width
- QW, 16, quotient width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_req0_valid / i_req1_valid  in  1  request valid per requester
- i_req0_dividend / i_req1_dividend  in  DW  dividend
- i_req0_divisor / i_req1_divisor  in  DW  divisor
- o_req0_ready / o_req1_ready  out  1  grant; transfer occurs when valid && ready at a posedge
- o_div_valid  out  1  operand valid to divider (registered)
- o_div_dividend, o_div_divisor  out  DW  operands to divider (registered)
- i_div_valid  in  1  divider result valid
- i_div_quotient  in  QW  divider result
- o_res0_valid / o_res1_valid  out  1  result valid, one-cycle pulse per accepted request
- o_res0_quotient / o_res1_quotient  out  QW  quotient
- o_res0_divzero / o_res1_divzero  out  1  divisor was zero
- o_busy  out  1  any operation issued and not yet returned
- o_sync_err  out  1  sticky: divider valid disagreed with tag pipeline

## Operation

- Arbitration is combinational from both valids and a 1-bit priority pointer `ptr`; reset value is 0.
  - Both valid: grant requester `ptr`, then set `ptr` to the other requester.
  - One valid: grant it, then set `ptr` to the other requester.
  - None valid: no grant, `ptr` unchanged.
- At most one ready is high per cycle. A ready never rises without its valid.
- Requesters hold valid and operands stable until ready. There is no result backpressure: consumers always accept.
- On transfer, operands of the granted requester are registered onto o_div_*, and o_div_valid=1 the next cycle. Zero-divisor requests are still issued, so the slot preserves ordering.
- Tag pipeline: DIVIDE_LATENCY+1 stages of {valid, id, dz}.
  - A stage is loaded on transfer with id=granted index and dz=(divisor==0).
  - The pipeline shifts every cycle.
  - The last stage aligns with i_div_valid/i_div_quotient.
- Result stage (registered), driven when the last tag is valid:
  - o_res[id]_valid=1.
  - o_res[id]_quotient = dz ? 0 : i_div_quotient.
  - o_res[id]_divzero=dz.
  - The other requester's outputs have valid=0. Quotient/divzero hold their last value when valid is 0.
- Sync check: in a cycle where last-tag valid != i_div_valid, o_sync_err is set the next cycle and stays set until reset. If the tag is valid, the result is routed per tag regardless.
- o_busy = o_div_valid OR any tag stage valid.
- Reset values:
  - All outputs 0, `ptr`=0, all tag stages cleared.
  - While i_rst=1, ready=0 and no transfers occur.
  - Operations in flight at reset are discarded: quotients that arrive later produce no o_res*_valid, and do not set o_sync_err.
  - i_div_valid is ignored while every tag stage is invalid and the divider flush window has not expired. The window is DIVIDE_LATENCY+1 cycles after reset.

## Timing

- Transfer at posedge T.
- o_div_valid during cycle T+1.
- Divider output at T+1+DIVIDE_LATENCY.
- o_resN_valid during cycle T+2+DIVIDE_LATENCY. Default latency is 18 cycles.
- Throughput is one operation per cycle, aggregate across both requesters.
- Results return in issue order.
- Simultaneous transfer and return in the same cycle are independent. o_busy stays 1 while both happen.

## Test plan

Bench divider model: quotient = floor((dividend<<8)/divisor), latency 16, i_div_valid asserted for every issued operation.
- After reset, req0 5/2 alone:
  - o_req0_ready=1 in the same cycle.
  - o_res0_valid exactly 18 cycles later, quotient 0x0280, divzero 0.
  - o_res1_valid never asserts.
- req0 and req1 both continuously valid for 4 cycles, with req0 1/3 and 3/2 and req1 10/3 and 3/2:
  - Grants are 0,1,0,1.
  - Results, each 18 cycles after its grant: res0 0x0055, res1 0x0355, res0 0x0180, res1 0x0180.
- req1 25/0 and req1 42/0:
  - o_div_valid pulses for each.
  - res1 quotient 0, divzero 1, for both.
- Issue 3 operations, then assert i_rst for one cycle 5 cycles later:
  - No o_res*_valid for them.
  - o_busy=0 after reset.
  - o_sync_err stays 0.
- Model suppresses one i_div_valid:
  - o_sync_err=1 the following cycle and stays high.
  - The result for that operation is still routed per its tag.
- req0 alone, continuously valid for 20 cycles:
  - Ready every cycle.
  - 20 consecutive o_res0_valid pulses starting 18 cycles after the first.
